pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
Parametrised instruction-fetch unit that owns the program counter and the instruction memory. It holds the PC register, sequences it (increment, branch, stall, halt), and performs a registered read of instruction memory. It returns each instruction with its PC and a valid flag to the instruction-decode controller. In IDLE, a write port allows the instruction memory to be loaded before execution starts.

Parameters:
PC_WIDTH, 8, width of PC and all address ports
INSTR_WIDTH, 59, instruction word width
DEPTH, 256, number of instruction words; legal range 2..2**PC_WIDTH
RESET_PC, 0, PC value on reset and on start from IDLE; must be < DEPTH

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
wr_en  in  1  program-load write strobe, honoured only in IDLE
wr_addr  in  PC_WIDTH  program-load address
wr_data  in  INSTR_WIDTH  program-load data
start  in  1  IDLE->RUN or HALT->RUN
halt_req  in  1  RUN->HALT
stall  in  1  freeze fetch pipeline for this cycle (RUN only)
branch_valid  in  1  redirect PC to branch_target (RUN only)
branch_target  in  PC_WIDTH  redirect address
pc  out  PC_WIDTH  address of the next fetch
instr  out  INSTR_WIDTH  fetched instruction
instr_pc  out  PC_WIDTH  address instr was read from
instr_valid  out  1  instr/instr_pc valid this cycle
running  out  1  high while state == RUN
addr_err  out  1  one-cycle pulse on out-of-range branch

Behaviour:
- Reset (rst=1, any state, mid-operation included), effective at the next edge: state=IDLE, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, running=0, addr_err=0. Memory contents are not cleared.
- States: IDLE, RUN, HALT.
- IDLE:
  - wr_en=1 writes wr_data into mem[wr_addr] at the edge. A write with wr_addr >= DEPTH is dropped.
  - start=1 -> RUN with pc=RESET_PC.
  - instr_valid=0.
  - Other control inputs are ignored.
- RUN, evaluated each cycle in this priority order:
  1. halt_req=1 -> HALT; instr_valid<=0; pc holds. If branch_valid=1 in the same cycle, pc<=branch_target first (with the range check below).
  2. branch_valid=1:
     - If branch_target < DEPTH: pc<=branch_target, instr_valid<=0, so the sequential fetch issued this cycle is squashed.
     - If branch_target >= DEPTH: addr_err<=1 for one cycle, state->HALT, pc holds, instr_valid<=0.
     - branch_valid wins over stall.
  3. stall=1: pc, instr, instr_pc and instr_valid all hold their values.
  4. Otherwise:
     - instr<=mem[pc], instr_pc<=pc, instr_valid<=1.
     - pc<=pc+1, or pc<=0 when pc==DEPTH-1 (wrap at DEPTH, not at 2**PC_WIDTH).
- Read latency: exactly 1 cycle, so the instruction for pc=N is on instr the cycle after N is presented. After RUN entry or a branch, the first instr_valid=1 appears 1 cycle later; there are no bubbles otherwise.
- HALT:
  - instr_valid=0; pc holds.
  - start=1 -> RUN, resuming fetch at the held pc.
  - Writes are ignored.
- start while in RUN is ignored. wr_en while in RUN or HALT is ignored; memory is unchanged.
- running is a registered decode of state == RUN.
- addr_err is high for exactly one cycle per faulting branch.
- Write and read never coincide, because writes occur only in IDLE.

Test Plan:
1. Load mem[0..3]=A,B,C,D in IDLE, pulse start -> instr_valid rises the cycle after RUN entry; instr/instr_pc = A/0, B/1, C/2, D/3 on consecutive cycles; running=1.
2. DEPTH=4, PC_WIDTH=3, run from 0 -> instr_pc sequence 0,1,2,3,0,1 with no bubble at the wrap.
3. In RUN at pc=5, branch_valid=1 with target=20 -> next cycle instr_valid=0 and pc=20; following cycle instr=mem[20], instr_pc=20. Repeat with stall=1 in the same cycle -> identical result (branch priority).
4. stall=1 for 3 cycles at pc=7 -> pc stays 7; instr, instr_pc and instr_valid are frozen at the values for address 6; on release, instr_pc=7 follows.
5. DEPTH=200, branch_target=250 -> addr_err=1 for one cycle, state HALT, pc unchanged, instr_valid=0; start -> resumes at the held pc. halt_req at pc=9, then start -> first instr_pc=9.
6. rst asserted mid-RUN at pc=33 -> next edge: pc=RESET_PC, instr_valid=0, running=0, IDLE; previously loaded memory still reads back correctly after start. wr_en in RUN to address 0 -> mem[0] unchanged.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch unit: owns the PC, sequences it through IDLE/RUN/HALT and
// returns each instruction with its address one cycle after the PC presents it.
module pc_fetch_unit #(
    parameter int unsigned PC_WIDTH    = 8,
    parameter int unsigned INSTR_WIDTH = 59,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned RESET_PC    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [PC_WIDTH-1:0]    wr_addr,
    input  logic [INSTR_WIDTH-1:0] wr_data,
    input  logic                   start,
    input  logic                   halt_req,
    input  logic                   stall,
    input  logic                   branch_valid,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    instr_pc,
    output logic                   instr_valid,
    output logic                   running,
    output logic                   addr_err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PC_WIDTH-1:0] PC_RST  = PC_WIDTH'(RESET_PC);
    localparam logic [PC_WIDTH-1:0] PC_LAST = PC_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [PC_WIDTH-1:0]    instr_pc_q, instr_pc_d;
    logic                   instr_valid_q, instr_valid_d;
    logic                   running_q, running_d;
    logic                   addr_err_q, addr_err_d;

    logic [INSTR_WIDTH-1:0] mem [DEPTH];
    logic                   tgt_ok;
    logic                   wr_ok;

    assign tgt_ok = 32'(branch_target) < DEPTH;
    assign wr_ok  = 32'(wr_addr) < DEPTH;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        addr_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                instr_valid_d = 1'b0;
                if (start) begin
                    state_d = RUN;
                    pc_d    = PC_RST;
                end
            end
            RUN: begin
                // halt and branch share the squash; a branch taken with halt still redirects pc
                if (halt_req || branch_valid) begin
                    instr_valid_d = 1'b0;
                    if (halt_req) state_d = HALT;
                    if (branch_valid) begin
                        if (tgt_ok) begin
                            pc_d = branch_target;
                        end else begin
                            addr_err_d = 1'b1;
                            state_d    = HALT;
                        end
                    end
                end else if (!stall) begin
                    instr_d       = mem[pc_q[AW-1:0]];
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    pc_d          = (pc_q == PC_LAST) ? '0 : pc_q + PC_WIDTH'(1);
                end
            end
            HALT: begin
                instr_valid_d = 1'b0;
                if (start) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= PC_RST;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            running_q     <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            running_q     <= running_d;
            addr_err_q    <= addr_err_d;
        end
    end

    // Program memory has no reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (!rst && state_q == IDLE && wr_en && wr_ok) begin
            mem[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign running     = running_q;
    assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed scoreboard bench for pc_fetch_unit: a DEPTH=200 instance for the main
// behaviour and a DEPTH=4 instance for wrap at DEPTH.
module tb_pc_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: PC_WIDTH=8, DEPTH=200.
    logic        rst, wr_en, start, halt_req, stall, branch_valid;
    logic [7:0]  wr_addr, branch_target;
    logic [58:0] wr_data;
    logic [7:0]  pc, instr_pc;
    logic [58:0] instr;
    logic        instr_valid, running, addr_err;

    pc_fetch_unit #(.PC_WIDTH(8), .INSTR_WIDTH(59), .DEPTH(200), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .halt_req(halt_req), .stall(stall),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .pc(pc), .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .running(running), .addr_err(addr_err)
    );

    // Small instance: PC_WIDTH=3, DEPTH=4.
    logic        s_rst, s_wr_en, s_start, s_halt_req, s_stall, s_branch_valid;
    logic [2:0]  s_wr_addr, s_branch_target, s_pc, s_instr_pc;
    logic [15:0] s_wr_data, s_instr;
    logic        s_instr_valid, s_running, s_addr_err;

    pc_fetch_unit #(.PC_WIDTH(3), .INSTR_WIDTH(16), .DEPTH(4), .RESET_PC(0)) dut_small (
        .clk(clk), .rst(s_rst), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .start(s_start), .halt_req(s_halt_req), .stall(s_stall),
        .branch_valid(s_branch_valid), .branch_target(s_branch_target),
        .pc(s_pc), .instr(s_instr), .instr_pc(s_instr_pc), .instr_valid(s_instr_valid),
        .running(s_running), .addr_err(s_addr_err)
    );

    typedef struct {
        logic [7:0]  pc;
        logic        v;
        logic        run;
        logic        err;
        logic        chk;
        logic [58:0] ins;
        logic [7:0]  ipc;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int unsigned sb2[$];
    int          n_assert = 0;
    int          n_fail   = 0;

    function automatic logic [58:0] img(int unsigned a);
        return {3'b101, 8'(a), 48'hC0DE_0000_0000 | 48'(a * 32'd7919)};
    endfunction

    function automatic logic [15:0] img2(int unsigned a);
        return {8'hB5, 8'(a * 8'd17)};
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk); #1;
        e = sb.pop_front();
        check({e.tag, "/pc"},       64'(pc),          64'(e.pc));
        check({e.tag, "/valid"},    64'(instr_valid), 64'(e.v));
        check({e.tag, "/running"},  64'(running),     64'(e.run));
        check({e.tag, "/addr_err"}, 64'(addr_err),    64'(e.err));
        if (e.chk) begin
            check({e.tag, "/instr"},    64'(instr),    64'(e.ins));
            check({e.tag, "/instr_pc"}, 64'(instr_pc), 64'(e.ipc));
        end
    endtask

    task automatic step(string tag, logic [7:0] epc, logic ev, logic erun, logic eerr,
                        logic echk, logic [58:0] eins, logic [7:0] eipc);
        sb.push_back('{epc, ev, erun, eerr, echk, eins, eipc, tag});
        tick();
    endtask

    task automatic fetch(string tag, int unsigned ip, int unsigned npc);
        step(tag, 8'(npc), 1'b1, 1'b1, 1'b0, 1'b1, img(ip), 8'(ip));
    endtask

    task automatic bubble(string tag, int unsigned epc, logic erun, logic eerr);
        step(tag, 8'(epc), 1'b0, erun, eerr, 1'b0, '0, '0);
    endtask

    task automatic clr();
        wr_en = 0; wr_addr = '0; wr_data = '0; start = 0; halt_req = 0;
        stall = 0; branch_valid = 0; branch_target = '0;
    endtask

    task automatic branch(int unsigned tgt);
        branch_valid = 1; branch_target = 8'(tgt);
    endtask

    initial begin
        clr();
        rst = 1;
        s_rst = 1; s_wr_en = 0; s_wr_addr = '0; s_wr_data = '0; s_start = 0;
        s_halt_req = 0; s_stall = 0; s_branch_valid = 0; s_branch_target = '0;

        step("reset", 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        rst = 0;

        // Program load; run-time controls are ignored while idle.
        for (int a = 0; a < 200; a++) begin
            wr_en = 1; wr_addr = 8'(a); wr_data = img(a);
            stall = (a == 10); halt_req = (a == 10); branch_valid = (a == 10);
            branch_target = 8'd250;
            bubble("idle_load", 0, 1'b0, 1'b0);
        end
        clr();

        start = 1; bubble("start", 0, 1'b1, 1'b0); clr();
        wr_en = 1; wr_addr = 8'd0; wr_data = ~img(0);
        fetch("seq0", 0, 1); clr();
        for (int i = 1; i < 5; i++) fetch("seq", i, i + 1);

        branch(20); bubble("br", 20, 1'b1, 1'b0); clr();
        fetch("br_tgt", 20, 21);
        fetch("br_next", 21, 22);
        branch(20); stall = 1; bubble("br_stall", 20, 1'b1, 1'b0); clr();
        fetch("br_stall_tgt", 20, 21);

        branch(6); bubble("br6", 6, 1'b1, 1'b0); clr();
        fetch("pre_stall", 6, 7);
        stall = 1;
        for (int i = 0; i < 3; i++) fetch("stall_hold", 6, 7);
        clr();
        fetch("stall_release", 7, 8);

        branch(0); bubble("br0", 0, 1'b1, 1'b0); clr();
        fetch("run_write_dropped", 0, 1);

        branch(198); bubble("br198", 198, 1'b1, 1'b0); clr();
        fetch("pre_wrap", 198, 199);
        fetch("wrap_last", 199, 0);
        fetch("wrap_zero", 0, 1);

        branch(250); bubble("err250", 1, 1'b0, 1'b1); clr();
        bubble("err_pulse_end", 1, 1'b0, 1'b0);
        wr_en = 1; wr_addr = 8'd3; wr_data = ~img(3); stall = 1; branch(250);
        bubble("halt_ignores", 1, 1'b0, 1'b0); clr();
        start = 1; bubble("resume", 1, 1'b1, 1'b0); clr();
        fetch("resume_fetch", 1, 2);

        branch(200); bubble("err200", 2, 1'b0, 1'b1); clr();
        start = 1; bubble("resume2", 2, 1'b1, 1'b0); clr();
        fetch("resume2_fetch", 2, 3);
        fetch("halt_write_dropped", 3, 4);
        for (int i = 4; i < 9; i++) fetch("seq_to9", i, i + 1);

        halt_req = 1; bubble("halt9", 9, 1'b0, 1'b0); clr();
        bubble("halted", 9, 1'b0, 1'b0);
        start = 1; bubble("restart9", 9, 1'b1, 1'b0); clr();
        fetch("first_after_halt", 9, 10);

        halt_req = 1; branch(50); bubble("halt_br", 50, 1'b0, 1'b0); clr();
        start = 1; bubble("restart50", 50, 1'b1, 1'b0); clr();
        fetch("halt_br_fetch", 50, 51);
        start = 1; fetch("start_in_run", 51, 52); clr();

        branch(199); bubble("br199", 199, 1'b1, 1'b0); clr();
        fetch("br199_fetch", 199, 0);

        branch(32); bubble("br32", 32, 1'b1, 1'b0); clr();
        fetch("pre_rst", 32, 33);
        rst = 1; start = 1; branch(5);
        step("rst_mid", 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        rst = 0; clr();
        bubble("idle_after_rst", 0, 1'b0, 1'b0);
        start = 1; bubble("start_after_rst", 0, 1'b1, 1'b0); clr();
        fetch("mem_kept0", 0, 1);
        fetch("mem_kept1", 1, 2);

        // Small instance: wrap at DEPTH=4 without bubbles.
        s_rst = 0;
        for (int a = 0; a < 4; a++) begin
            s_wr_en = 1; s_wr_addr = 3'(a); s_wr_data = img2(a);
            @(posedge clk); #1;
        end
        s_wr_en = 0; s_start = 1;
        @(posedge clk); #1;
        s_start = 0;
        check("small_start/valid", 64'(s_instr_valid), 64'd0);
        check("small_start/running", 64'(s_running), 64'd1);
        for (int k = 0; k < 6; k++) begin
            int unsigned ip;
            sb2.push_back(k % 4);
            @(posedge clk); #1;
            ip = sb2.pop_front();
            check("small_wrap/instr_pc", 64'(s_instr_pc), 64'(ip));
            check("small_wrap/instr", 64'(s_instr), 64'(img2(ip)));
            check("small_wrap/valid", 64'(s_instr_valid), 64'd1);
            check("small_wrap/pc", 64'(s_pc), 64'((ip + 1) % 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
